seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter MUL_EN, default 1; when 1, opcode 14 (MUL) is implemented; when 0, opcode 14 is treated as reserved.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  request present on a/b/opcode.
REQ-006 Port in_ready  output  1  block can accept a request this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port opcode  input  4  operation select, see REQ-013.
REQ-010 Port out_valid  output  1  result and flags valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Ports result  output  WIDTH; zero, carry, neg, ovf  output  1 each; busy  output  1 (high in EXEC).

Function
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL1, 7 SHR1, 8 ADC, 9 SBB, 10 ROL1, 11 ROR1, 12 SHL by n, 13 SHR by n, 14 MUL (low half), 15 reserved.
REQ-014 Opcodes 0-7: result and carry identical to the legacy 8-bit ALU. ADD carry = bit WIDTH of A+B. SUB carry = borrow, 1 iff A<B unsigned. Carry = 0 for opcodes 2-7.
REQ-015 ADC = A+B+cf. SBB = A-B-cf. cf is the internal sticky carry register; carry uses the same conventions as ADD/SUB.
REQ-016 ROL1/ROR1: rotate by one bit; carry = bit rotated across the end.
REQ-017 SHL/SHR by n: n = b[clog2(WIDTH)-1:0]; zero-fill; carry = last bit shifted out (0 if n=0).
REQ-018 MUL: unsigned; result = low WIDTH bits of product; carry = 1 iff the high half is nonzero.
REQ-019 Reserved opcode: result = 0, zero = 1, other flags 0, latency 1.
REQ-020 Flags: zero = (result==0); neg = result[WIDTH-1]; ovf = signed overflow for opcodes 0,1,8,9, else 0.
REQ-021 FSM states: IDLE, EXEC, DONE.
REQ-022 Acceptance: a request is accepted when in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-023 Single-cycle ops (all except 12, 13 with n>0, and 14): go from accept to DONE; out_valid is asserted in the next cycle (latency 1).
REQ-024 Iterative ops: accept leads to EXEC, one bit per cycle. SHL/SHR take n cycles; MUL takes WIDTH cycles. Then go to DONE, so out_valid latency = n+1 or WIDTH+1.
REQ-025 DONE: result/flags are held stable until out_valid & out_ready.
  - If out_ready with no new accept, go to IDLE.
  - If out_ready with a simultaneous accept, go to the new op's path with no bubble.
REQ-026 cf is updated with carry on entry to DONE. An ADC/SBB accepted back-to-back in DONE uses the cf just produced.
REQ-027 Inputs are ignored in EXEC. a/b/opcode are captured at accept; later input changes do not affect the op in flight.

Reset
REQ-028 While rst_n=0, outputs are forced immediately (asynchronously):
  - state = IDLE, cf = 0;
  - result = 0; zero, carry, neg, ovf = 0;
  - out_valid = 0, busy = 0, in_ready = 0.
REQ-029 Reset assertion mid-EXEC or mid-DONE discards the operation. After release, in_ready = 1 from the first clock edge.

Structure
REQ-030 Shared package alu_pkg holds the opcode enum (4-bit), the FSM state enum, and a function giving the counter width from WIDTH.
REQ-031 One sub-module, alu_iter_unit, holds the iterative shift/multiply datapath: operand, accumulator and count registers, start/done strobes. seq_alu holds the FSM, single-cycle logic, flags and cf.

Verification (WIDTH=8)
REQ-032 ADD a=0xFF b=0x01 -> one cycle later result=0x00, zero=1, carry=1, ovf=0. Then ADC a=0x00 b=0x00 -> result=0x01, carry=0.
REQ-033 SUB a=0x80 b=0x01 -> result=0x7F, carry=0, ovf=1, neg=0. SUB a=0x01 b=0x02 -> result=0xFF, carry=1, neg=1.
REQ-034 MUL a=0x10 b=0x11 -> busy for 8 cycles, out_valid at cycle 9, result=0x10, carry=1. in_ready=0 throughout EXEC.
REQ-035 SHL by n a=0x81 b=0x03 -> out_valid after 4 cycles, result=0x08, carry=0. SHR n=0 a=0x81 -> latency 1, result=0x81, carry=0.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after AND a=0xF0 b=0x3C -> result 0x30 stable. Raise out_ready together with a new XOR request -> next cycle out_valid=1, result=0xCC, no idle gap.
REQ-037 Assert rst_n=0 mid-MUL -> out_valid=0, busy=0 at once. After release, in_ready=1 and a following ADC 0x01+0x01 gives 0x02 (cf cleared).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bundle and
// the width helper for the iteration counter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL1 = 4'd6,
    OP_SHR1 = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBB  = 4'd9,
    OP_ROL1 = 4'd10,
    OP_ROR1 = 4'd11,
    OP_SHLN = 4'd12,
    OP_SHRN = 4'd13,
    OP_MUL  = 4'd14,
    OP_RSVD = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } flags_t;

  // Counter must hold WIDTH itself (the multiply step count).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifts (by n) and shift-add multiply.
// start_i loads operands; done_o flags the final step, whose outcome is
// presented combinationally on result_o/carry_o in that same cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       mul_i,
  input  logic                       left_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [$clog2(WIDTH)-1:0]   n_i,
  output logic                       done_o,
  output logic [WIDTH-1:0]           result_o,
  output logic                       carry_o
);

  localparam int CW = cnt_width(WIDTH);

  logic               active_q;
  logic               mul_q;
  logic               left_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   sh_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_carry;
  logic [2*WIDTH-1:0] acc_nxt;

  // One step of the shifter and of the multiplier.
  assign sh_nxt   = left_q ? (sh_q << 1) : (sh_q >> 1);
  assign sh_carry = left_q ? sh_q[WIDTH-1] : sh_q[0];
  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign done_o   = active_q && (cnt_q == CW'(1));
  assign result_o = mul_q ? acc_nxt[WIDTH-1:0] : sh_nxt;
  assign carry_o  = mul_q ? |acc_nxt[2*WIDTH-1:WIDTH] : sh_carry;

  // Load operands on start, then advance one bit per cycle until count expires.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      mul_q    <= 1'b0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      mul_q    <= mul_i;
      left_q   <= left_i;
      cnt_q    <= mul_i ? CW'(WIDTH) : CW'(n_i);
      sh_q     <= a_i;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (active_q) begin
      sh_q     <= sh_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_nxt;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake. Single-cycle ops complete in one
// cycle; shift-by-n and multiply run in alu_iter_unit. Results and flags are
// held in DONE until the consumer takes them.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q;
  flags_t             flags_q;
  logic               cf_q;

  opcode_e            op;
  logic [SHW-1:0]     n;
  logic               is_mul, iter_req, accept;
  logic               start, load, sel_iter;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   s_res, res_d, iter_res;
  flags_t             s_flags, flags_d;
  logic               iter_done, iter_carry;

  assign op       = opcode_e'(opcode);
  assign n        = b[SHW-1:0];
  assign is_mul   = (op == OP_MUL) && (MUL_EN != 0);
  assign iter_req = is_mul || (((op == OP_SHLN) || (op == OP_SHRN)) && (n != '0));

  // Reset gating keeps in_ready low while rst_n is asserted.
  assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_EXEC);
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .mul_i    (is_mul),
    .left_i   (op == OP_SHLN),
    .a_i      (a),
    .b_i      (b),
    .n_i      (n),
    .done_o   (iter_done),
    .result_o (iter_res),
    .carry_o  (iter_carry)
  );

  // Single-cycle result and flags, computed from the live request inputs.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ext     = '0;
    s_res   = '0;
    s_flags = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        ext           = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) && cf_q};
        s_res         = ext[WIDTH-1:0];
        s_flags.carry = ext[WIDTH];
        s_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        ext           = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) && cf_q};
        s_res         = ext[WIDTH-1:0];
        s_flags.carry = ext[WIDTH];
        s_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_XOR:  s_res = a ^ b;
      OP_NOT:  s_res = ~a;
      OP_SHL1: s_res = a << 1;
      OP_SHR1: s_res = a >> 1;
      OP_ROL1: begin
        s_res         = {a[WIDTH-2:0], a[WIDTH-1]};
        s_flags.carry = a[WIDTH-1];
      end
      OP_ROR1: begin
        s_res         = {a[0], a[WIDTH-1:1]};
        s_flags.carry = a[0];
      end
      // Only reached here for a zero shift count: pass A through.
      OP_SHLN, OP_SHRN: s_res = a;
      // Reserved codes (and MUL when disabled) produce zero with clear flags.
      default: s_res = '0;
    endcase
    s_flags.zero = (s_res == '0);
    s_flags.neg  = s_res[WIDTH-1];
  end

  // Select which datapath feeds the output registers.
  always_comb begin
    res_d         = sel_iter ? iter_res : s_res;
    flags_d       = s_flags;
    if (sel_iter) begin
      flags_d.zero  = (iter_res == '0);
      flags_d.carry = iter_carry;
      flags_d.neg   = iter_res[WIDTH-1];
      flags_d.ovf   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes; DONE may accept a new op with no bubble.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    load     = 1'b0;
    sel_iter = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (iter_req) begin
            state_d = ST_EXEC;
            start   = 1'b1;
          end else begin
            state_d = ST_DONE;
            load    = 1'b1;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (iter_done) begin
          state_d  = ST_DONE;
          load     = 1'b1;
          sel_iter = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers and sticky carry, updated on every entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      cf_q     <= 1'b0;
    end else if (load) begin
      result_q <= res_d;
      flags_q  <= flags_d;
      cf_q     <= flags_d.carry;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=8, MUL_EN=1).
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, carry, neg, ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .neg       (neg),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] r,
                           input logic z, input logic c, input logic ng, input logic o);
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".zero"},   32'(zero),   32'(z));
    check({tag, ".carry"},  32'(carry),  32'(c));
    check({tag, ".neg"},    32'(neg),    32'(ng));
    check({tag, ".ovf"},    32'(ovf),    32'(o));
  endtask

  // Present one request now (caller is just after a falling edge), scramble
  // the inputs after acceptance, and wait (bounded) for out_valid.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [7:0] av, input logic [7:0] bv, input int exp_lat);
    int lat;
    lat      = 0;
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        opcode   = OP_SUB;
      end
      if (!out_valid) begin
        check({tag, ".busy"},     32'(busy),     32'd1);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
      end
    end while (!out_valid && lat < 40);
    check({tag, ".latency"},   32'(lat),  32'(exp_lat));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rel.in_ready",  32'(in_ready),  32'd1);
    check("rel.out_valid", 32'(out_valid), 32'd0);

    // Add/sub family and sticky carry, issued back-to-back
    run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1);
    check_out("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("adc_00_00", OP_ADC, 8'h00, 8'h00, 1);
    check_out("adc_00_00", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 1);
    check_out("sub_80_01", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub_01_02", OP_SUB, 8'h01, 8'h02, 1);
    check_out("sub_01_02", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("sbb_05_02", OP_SBB, 8'h05, 8'h02, 1);
    check_out("sbb_05_02", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 1);
    check_out("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

    // Logic, rotate and single-bit shifts
    run_op("rol1_81", OP_ROL1, 8'h81, 8'h00, 1);
    check_out("rol1_81", 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ror1_81", OP_ROR1, 8'h81, 8'h00, 1);
    check_out("ror1_81", 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("not_0f", OP_NOT, 8'h0F, 8'h00, 1);
    check_out("not_0f", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("shl1_81", OP_SHL1, 8'h81, 8'h00, 1);
    check_out("shl1_81", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("rsvd", OP_RSVD, 8'hFF, 8'hFF, 1);
    check_out("rsvd", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Iterative ops
    run_op("mul_10_11", OP_MUL, 8'h10, 8'h11, 9);
    check_out("mul_10_11", 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("shln_81_3", OP_SHLN, 8'h81, 8'h03, 4);
    check_out("shln_81_3", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("shrn_81_0", OP_SHRN, 8'h81, 8'h00, 1);
    check_out("shrn_81_0", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("shrn_83_fa", OP_SHRN, 8'h83, 8'hFA, 3);
    check_out("shrn_83_fa", 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure then a new request with no bubble
    run_op("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 1);
    check_out("and_f0_3c", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.result",    32'(result),    32'h30);
      check("hold.in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    run_op("xor_nobubble", OP_XOR, 8'hF0, 8'h3C, 1);
    check_out("xor_nobubble", 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a multiply, with cf set beforehand
    run_op("add_cf", OP_ADD, 8'hFF, 8'h01, 1);
    check_out("add_cf", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    opcode   = OP_MUL;
    a        = 8'h10;
    b        = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midmul.busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.busy",      32'(busy),      32'd0);
    check("arst.in_ready",  32'(in_ready),  32'd0);
    check("arst.result",    32'(result),    32'h00);
    check("arst.carry",     32'(carry),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_rel.in_ready", 32'(in_ready), 32'd1);
    run_op("adc_after_rst", OP_ADC, 8'h01, 8'h01, 1);
    check_out("adc_after_rst", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
